// File: rtl/lcd_write_engine.sv
// HD44780-class LCD write engine: valid/ready byte in, timed RS/DATA/EN strobes out,
// 8- or 4-bit bus, followed by a command execution wait before the next request is taken.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request; LCD_DATA/LCD_RS hold their last value
// S_SETUP | RS/DATA driven, EN low, address setup time running
// S_PULSE | EN high
// S_HOLD  | EN low, data hold time; then low nibble, EXEC or done
// S_EXEC  | waiting for the LCD to execute the write
module lcd_write_engine #(
  parameter int DATA_MODE   = 8,
  parameter int T_AS        = 2,
  parameter int T_PW        = 16,
  parameter int T_H         = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iNib,
  input  logic       iValid,
  output logic       oReady,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  localparam bit FOUR_BIT = (DATA_MODE == 4);
  localparam logic [CNT_W-1:0] C_AS   = CNT_W'(T_AS);
  localparam logic [CNT_W-1:0] C_PW   = CNT_W'(T_PW);
  localparam logic [CNT_W-1:0] C_H    = CNT_W'(T_H);
  localparam logic [CNT_W-1:0] C_EX   = CNT_W'(T_EXEC);
  localparam logic [CNT_W-1:0] C_EXL  = CNT_W'(T_EXEC_LONG);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lo_q, lo_d;
  logic             second_q, second_d;
  logic             long_q, long_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_last;
  logic [CNT_W-1:0] exec_len;

  // <= 1 rather than == 1 so a stray zero load can never wrap the timer
  assign cnt_last = (cnt_q <= C_ONE);
  assign exec_len = long_q ? C_EXL : C_EX;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    second_d = second_q;
    long_d   = long_q;
    data_d   = data_q;
    rs_d     = rs_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iValid && ready_q) begin
          state_d  = S_SETUP;
          cnt_d    = C_AS;
          lo_d     = iDATA[3:0];
          rs_d     = iRS;
          second_d = FOUR_BIT && !iNib;
          long_d   = !iRS && (iDATA[7:2] == 6'd0) && (iDATA[1:0] != 2'd0);
          data_d   = FOUR_BIT ? {iDATA[7:4], 4'h0} : iDATA;
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          state_d = S_PULSE;
          cnt_d   = C_PW;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_last) begin
          state_d = S_HOLD;
          cnt_d   = C_H;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_HOLD: begin
        if (!cnt_last) begin
          cnt_d = cnt_q - C_ONE;
        end else if (second_q) begin
          state_d  = S_SETUP;
          cnt_d    = C_AS;
          second_d = 1'b0;
          data_d   = {lo_q, 4'h0};
        end else if (exec_len != '0) begin
          state_d = S_EXEC;
          cnt_d   = exec_len;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    en_d    = (state_d == S_PULSE);
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lo_q     <= 4'h0;
      second_q <= 1'b0;
      long_q   <= 1'b0;
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      second_q <= second_d;
      long_q   <= long_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign oReady   = ready_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: an 8-bit and a 4-bit instance, driven by directed and random
// requests; expected strobe/done events are queued per instance and checked by monitors.
module tb_lcd_write_engine;

  localparam int TAS  = 2;
  localparam int TPW  = 4;
  localparam int TH   = 2;
  localparam int TEX  = 10;
  localparam int TEXL = 50;
  localparam int CW   = 8;
  localparam int P    = TAS + TPW + TH;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] d   [2];
  logic       rsi [2];
  logic       nib [2];
  logic       vld [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       dn  [2];
  logic       en  [2];
  logic       rw  [2];
  logic       lrs [2];
  logic [7:0] ld  [2];

  typedef struct {
    int         kind;   // 0 EN rise, 1 EN fall, 2 done
    int         cyc;
    logic [7:0] data;
    logic       rs;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  lcd_write_engine #(
    .DATA_MODE(8), .T_AS(TAS), .T_PW(TPW), .T_H(TH),
    .T_EXEC(TEX), .T_EXEC_LONG(TEXL), .CNT_W(CW)
  ) u_dut8 (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(d[0]), .iRS(rsi[0]), .iNib(nib[0]),
    .iValid(vld[0]), .oReady(rdy[0]), .oBusy(bsy[0]), .oDone(dn[0]),
    .LCD_DATA(ld[0]), .LCD_RW(rw[0]), .LCD_RS(lrs[0]), .LCD_EN(en[0])
  );

  lcd_write_engine #(
    .DATA_MODE(4), .T_AS(TAS), .T_PW(TPW), .T_H(TH),
    .T_EXEC(TEX), .T_EXEC_LONG(TEXL), .CNT_W(CW)
  ) u_dut4 (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(d[1]), .iRS(rsi[1]), .iNib(nib[1]),
    .iValid(vld[1]), .oReady(rdy[1]), .oBusy(bsy[1]), .oDone(dn[1]),
    .LCD_DATA(ld[1]), .LCD_RW(rw[1]), .LCD_RS(lrs[1]), .LCD_EN(en[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int idx, input int kind, input int c,
                         input logic [7:0] data, input logic rs);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    e.rs   = rs;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Reference: list of timed events a request accepted at edge a must produce
  task automatic expect_xfer(input int idx, input int a, input logic [7:0] b,
                             input logic r, input logic n);
    int         nw;
    int         ex;
    logic [7:0] wv [2];
    nw = (idx == 1 && !n) ? 2 : 1;
    ex = (!r && b != 8'h00 && b < 8'h04) ? TEXL : TEX;
    wv[0] = (idx == 0) ? b : {b[7:4], 4'h0};
    wv[1] = {b[3:0], 4'h0};
    for (int w = 0; w < nw; w++) begin
      push_ev(idx, 0, a + w * P + TAS, wv[w], r);
      push_ev(idx, 1, a + w * P + TAS + TPW, wv[w], r);
    end
    push_ev(idx, 2, a + nw * P + ex, wv[nw-1], r);
  endtask

  task automatic monitor(input int idx);
    logic pen;
    int   kk;
    bit   empty;
    ev_t  e;
    pen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pen = 1'b0;
      end else begin
        for (int j = 0; j < 2; j++) begin
          kk = -1;
          if (j == 0) begin
            if (en[idx] && !pen) kk = 0;
            else if (!en[idx] && pen) kk = 1;
          end else if (dn[idx]) begin
            kk = 2;
          end
          if (kk >= 0) begin
            empty = 1'b0;
            if (idx == 0) begin
              if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            end else begin
              if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            end
            if (empty) begin
              chk($sformatf("dut%0d_unexpected_event_kind%0d", idx, kk), 1, 0);
            end else begin
              chk($sformatf("dut%0d_event_kind", idx), kk, e.kind);
              chk($sformatf("dut%0d_event%0d_cycle", idx, kk), cyc, e.cyc);
              chk($sformatf("dut%0d_event%0d_lcd_data", idx, kk), ld[idx], e.data);
              chk($sformatf("dut%0d_event%0d_lcd_rs", idx, kk), lrs[idx], e.rs);
              chk($sformatf("dut%0d_lcd_rw", idx), rw[idx], 0);
              if (kk == 2) begin
                chk($sformatf("dut%0d_ready_at_done", idx), rdy[idx], 1);
                chk($sformatf("dut%0d_busy_at_done", idx), bsy[idx], 0);
              end
            end
          end
        end
        pen = en[idx];
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic issue(input int idx, input logic [7:0] b, input logic r,
                       input logic n, output int a);
    int w;
    w = 0;
    d[idx]   = b;
    rsi[idx] = r;
    nib[idx] = n;
    vld[idx] = 1'b1;
    while (!rdy[idx] && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[idx]) begin
      chk($sformatf("dut%0d_accept_timeout", idx), 0, 1);
      vld[idx] = 1'b0;
      a = -1;
    end else begin
      a = cyc + 1;
      expect_xfer(idx, a, b, r, n);
      @(posedge clk);
      #1;
      chk($sformatf("dut%0d_ready_after_accept", idx), rdy[idx], 0);
      chk($sformatf("dut%0d_busy_after_accept", idx), bsy[idx], 1);
    end
  endtask

  task automatic wait_done(input int idx, input int a, input int off, input string name);
    int w;
    for (w = 0; w < 300 && !dn[idx]; w++) @(negedge clk);
    chk(name, dn[idx] ? (cyc - a) : -1, off);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_dut%0d_ready", tag, i), rdy[i], 1);
      chk($sformatf("%s_dut%0d_busy", tag, i), bsy[i], 0);
      chk($sformatf("%s_dut%0d_done", tag, i), dn[i], 0);
      chk($sformatf("%s_dut%0d_en", tag, i), en[i], 0);
      chk($sformatf("%s_dut%0d_data", tag, i), ld[i], 0);
      chk($sformatf("%s_dut%0d_rs", tag, i), lrs[i], 0);
      chk($sformatf("%s_dut%0d_rw", tag, i), rw[i], 0);
    end
  endtask

  initial begin
    int         a;
    int         a2;
    int         idx;
    logic [7:0] b;
    logic       r;
    logic       n;

    for (int i = 0; i < 2; i++) begin
      d[i] = 8'h00; rsi[i] = 1'b0; nib[i] = 1'b0; vld[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");

    // 8-bit data write
    issue(0, 8'h41, 1'b1, 1'b0, a);
    vld[0] = 1'b0;
    chk("t1_data_edge0", ld[0], 8'h41);
    chk("t1_rs_edge0", lrs[0], 1);
    wait_done(0, a, 18, "t1_done_edge");
    @(negedge clk);
    chk("t1_done_one_cycle", dn[0], 0);

    // execution wait selection
    issue(0, 8'h01, 1'b0, 1'b0, a);
    vld[0] = 1'b0;
    wait_done(0, a, 58, "t2_clear_done_edge");
    issue(0, 8'h01, 1'b1, 1'b0, a);
    vld[0] = 1'b0;
    wait_done(0, a, 18, "t2_data01_done_edge");
    issue(0, 8'h38, 1'b0, 1'b0, a);
    vld[0] = 1'b0;
    wait_done(0, a, 18, "t2_cmd38_done_edge");

    // 4-bit, two nibbles
    issue(1, 8'hA5, 1'b1, 1'b0, a);
    vld[1] = 1'b0;
    chk("t3_data_edge0", ld[1], 8'hA0);
    wait_to(a + 7);
    chk("t3_data_edge7", ld[1], 8'hA0);
    wait_to(a + 8);
    chk("t3_data_edge8", ld[1], 8'h50);
    wait_done(1, a, 26, "t3_done_edge");

    // 4-bit single-nibble init write
    issue(1, 8'h30, 1'b0, 1'b1, a);
    vld[1] = 1'b0;
    chk("t4_data_edge0", ld[1], 8'h30);
    wait_done(1, a, 18, "t4_done_edge");

    // held valid, second request waits; iDATA wiggles during the first transfer
    issue(0, 8'h41, 1'b1, 1'b0, a);
    repeat (5) begin
      @(negedge clk);
      d[0] = 8'($urandom);
    end
    issue(0, 8'h42, 1'b1, 1'b0, a2);
    vld[0] = 1'b0;
    chk("t5_second_accept_edge", a2 - a, 19);
    wait_done(0, a2, 18, "t5_second_done_edge");

    // reset while EN is high
    issue(0, 8'h41, 1'b1, 1'b0, a);
    vld[0] = 1'b0;
    wait_to(a + 3);
    chk("t6_en_before_reset", en[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t6_en_in_reset", en[0], 0);
    chk("t6_busy_in_reset", bsy[0], 0);
    chk("t6_ready_in_reset", rdy[0], 1);
    chk("t6_done_in_reset", dn[0], 0);
    chk("t6_data_in_reset", ld[0], 0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(0, 8'h41, 1'b1, 1'b0, a);
    vld[0] = 1'b0;
    chk("t6_data_edge0", ld[0], 8'h41);
    wait_done(0, a, 18, "t6_done_edge");

    // random traffic on both instances
    for (int i = 0; i < 40; i++) begin
      idx = i % 2;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 3));
      else                           b = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      issue(idx, b, r, n, a);
      vld[idx] = 1'b0;
      d[idx]   = 8'($urandom);
      rsi[idx] = 1'($urandom_range(0, 1));
    end

    for (int w = 0; w < 400 && (q0.size() != 0 || q1.size() != 0); w++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("dut0_pending_events", q0.size(), 0);
    chk("dut1_pending_events", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
